ricevitore: RTL and testbench
=============================

Name: ricevitore

Overview:
- Asynchronous serial receiver; the counterpart of the team's serial transmitter.
- Frame on rxd: line idle at marking (1), start bit 0, 8 data bits LSB first, stop bit 1.
- Samples rxd at mid-bit using a clock-cycle bit timer, then assembles the byte.
- Hands each byte to a downstream consumer over the standard dav_/rfd handshake.
- Flags framing and overrun errors.

Parameters:
- BIT_CYCLES, 4: clock cycles per serial bit; even, >= 2.
- HALF, BIT_CYCLES/2: cycles from start-edge detection to the start-bit sample. Derived; not to be overridden.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-high. Sampled on posedge clock; overrides all other activity.
- rxd  in  1  serial line, asynchronous to clock.
- byte  out  8  received byte; stable while dav_=0.
- dav_  out  1  data valid, active-low; driven by this block (producer).
- rfd  in  1  ready for data from the consumer, active-high.
- fe  out  1  sticky framing error; set when a sampled stop bit is 0.
- ovr  out  1  sticky overrun; set when a good frame completes while the holding register is full.

Behaviour:
- Reset (posedge clock with reset=1):
  - dav_=1, fe=0, ovr=0, byte=8'h00.
  - Holding register empty.
  - Both synchronizer flops = 1.
  - Receive FSM = R_IDLE; handshake FSM = H_IDLE.
  - Any frame in progress is discarded.
- Input synchronizer: rxd passes through 2 flops, giving rxd_s (2-cycle latency). Everything below uses rxd_s only.
- Receive FSM (bit counter CNT: $clog2(BIT_CYCLES) bits; bit index IDX: 4 bits; shift register SR: 8 bits):
  - R_IDLE:
    - If rxd_s==0: CNT<=HALF-1, go R_START.
    - Else stay.
  - R_START: decrement CNT. When CNT==0, sample rxd_s:
    - 0 -> CNT<=BIT_CYCLES-1, IDX<=0, go R_DATA.
    - 1 -> false start; go R_IDLE with no flag set.
  - R_DATA: decrement CNT. When CNT==0:
    - SR<={rxd_s, SR[7:1]} (LSB first), CNT<=BIT_CYCLES-1, IDX<=IDX+1.
    - After the 8th sample (IDX==7) go R_STOP.
  - R_STOP: decrement CNT. When CNT==0, sample rxd_s:
    - 1 -> good frame: deliver SR (see holding rules), go R_IDLE.
    - 0 -> fe<=1, byte discarded, go R_BREAK.
  - R_BREAK: stay until rxd_s==1, then go R_IDLE. Prevents a held-low line from being read as repeated frames.
  - Mid-bit samples therefore fall at detection + HALF + k*BIT_CYCLES, k=0..9.
- Holding register and handshake:
  - Good frame with holding empty: byte<=SR and holding full, on the same edge as the stop sample.
  - Good frame with holding full: ovr<=1; new byte dropped; the held byte is unchanged.
  - H_IDLE: if holding full and rfd==1, dav_<=0, go H_WAIT.
  - H_WAIT: when rfd==0, dav_<=1, holding empty, go H_IDLE.
  - The next transfer waits for rfd==1 again, so the consumer must raise rfd before the next byte is offered.
- Simultaneous events:
  - If the holding register empties (H_WAIT sees rfd==0) on the same edge a good frame completes, the new byte is loaded and ovr is not set.
  - fe and a good frame cannot coincide.
- Latency: dav_ falls at the earliest 1 edge after the stop-bit sample edge, given rfd==1.
- Receiving continues independently of the consumer; only the single holding register buffers output.
- fe and ovr clear only on reset.

Decomposition:
- Shared package holds:
  - Receive FSM state encodings (R_IDLE, R_START, R_DATA, R_STOP, R_BREAK).
  - Handshake states (H_IDLE, H_WAIT).
  - DATA_BITS=8, START_BIT=0, STOP_BIT=1, MARKING=1. The transmitter reuses these frame constants.
- One sub-module: sync_2ff, the 2-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.
- The FSMs, counters and holding register stay in ricevitore.

Test Plan:
1. Frame 8'hA5, BIT_CYCLES=4, rfd=1 -> byte=8'hA5, dav_=0 one edge after the stop sample; rfd->0 gives dav_=1 next edge; fe=0, ovr=0.
2. Glitch: rxd low for 1 cycle while idle -> no dav_, no fe; FSM back in R_IDLE. A following frame 8'h3C is then received correctly.
3. Frame 8'h81 with stop bit 0, then line held low 20 cycles, then high -> fe=1, dav_ stays 1, no byte delivered. The next frame 8'h42 is received with fe still 1.
4. Two back-to-back frames 8'h11 then 8'h22 with rfd held 0 throughout -> byte=8'h11 held, ovr=1 after the second stop sample. Raising rfd delivers 8'h11 only.
5. Consumer drops rfd on exactly the edge the second frame's stop bit is sampled -> byte=8'h22 loaded, ovr=0, second handshake completes.
6. Assert reset during the 4th data bit, release, then send 8'hFF -> all outputs at reset values during reset; only 8'hFF is delivered afterwards.

Source files
------------

// File: rtl/ricevitore_pkg.sv
// rtl/ricevitore_pkg.sv - shared frame constants and FSM encodings for the serial receiver
package ricevitore_pkg;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  typedef enum logic {
    H_IDLE,
    H_WAIT
  } hs_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic MARKING   = 1'b1;

endpackage

// File: rtl/ricevitore_sync_2ff.sv
// rtl/ricevitore_sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ricevitore.sv
// rtl/ricevitore.sv - asynchronous serial receiver with mid-bit sampling and dav_/rfd output handshake
module ricevitore
  import ricevitore_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 dav_,
  input  logic                 rfd,
  output logic                 fe,
  output logic                 ovr
);

  localparam int HALF  = BIT_CYCLES / 2;
  localparam int CNT_W = $clog2(BIT_CYCLES);

  rx_state_t            rx_state;
  hs_state_t            hs_state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] sr;
  logic                 full;
  logic                 rxd_s;
  logic                 good_frame;
  logic                 hold_release;

  sync_2ff #(.RESET_VALUE(MARKING)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign good_frame   = (rx_state == R_STOP) && (cnt == '0) && (rxd_s == STOP_BIT);
  assign hold_release = (hs_state == H_WAIT) && !rfd;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= R_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sr       <= '0;
      fe       <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rxd_s == START_BIT) begin
            cnt      <= CNT_W'(HALF - 1);
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s == START_BIT) begin
            cnt      <= CNT_W'(BIT_CYCLES - 1);
            idx      <= '0;
            rx_state <= R_DATA;
          end else begin
            rx_state <= R_IDLE;
          end
        end
        R_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            sr  <= {rxd_s, sr[DATA_BITS-1:1]};
            cnt <= CNT_W'(BIT_CYCLES - 1);
            idx <= idx + 4'd1;
            if (idx == 4'(DATA_BITS - 1)) rx_state <= R_STOP;
          end
        end
        R_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s == STOP_BIT) begin
            rx_state <= R_IDLE;
          end else begin
            fe       <= 1'b1;
            rx_state <= R_BREAK;
          end
        end
        R_BREAK: begin
          // A line held low must go back to marking before a new start edge counts.
          if (rxd_s == MARKING) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_state <= H_IDLE;
      dav_     <= 1'b1;
      full     <= 1'b0;
      rx_byte  <= '0;
      ovr      <= 1'b0;
    end else begin
      case (hs_state)
        H_IDLE: begin
          if (full && rfd) begin
            dav_     <= 1'b0;
            hs_state <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (!rfd) begin
            dav_     <= 1'b1;
            full     <= 1'b0;
            hs_state <= H_IDLE;
          end
        end
        default: hs_state <= H_IDLE;
      endcase
      // A register emptied on this very edge can take the new byte.
      if (good_frame) begin
        if (!full || hold_release) begin
          rx_byte <= sr;
          full    <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ricevitore.sv
// tb/tb_ricevitore.sv - self-checking bench for the serial receiver
module tb_ricevitore;

  localparam int BIT_CYCLES = 4;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int STOP_LAT   = 3 + HALF + 9 * BIT_CYCLES + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd   = 1'b1;
  logic       rfd   = 1'b0;
  logic [7:0] rx_byte;
  logic       dav_, fe, ovr;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  ricevitore #(.BIT_CYCLES(BIT_CYCLES)) dut (
    .clock   (clock),
    .reset   (reset),
    .rxd     (rxd),
    .rx_byte (rx_byte),
    .dav_    (dav_),
    .rfd     (rfd),
    .fe      (fe),
    .ovr     (ovr)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(BIT_CYCLES);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_v);
  endtask

  task automatic wait_dav(input int budget, output int n, output bit seen);
    n = 0;
    seen = 0;
    while (n < budget && !seen) begin
      tick(1);
      n++;
      if (dav_ === 1'b0) seen = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxd = 1'b1;
    rfd = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd = 1'b1;
    rfd = 1'b0;
    tick(3);
    total++; if (dav_ !== 1'b1) begin bad++; $display("FAIL reset_dav got=%b want=1", dav_); end
    total++; if (fe !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", fe); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", ovr); end
    total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h want=00", rx_byte); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    int n;
    bit seen;
    do_reset();
    rfd = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      wait_dav(80, n, seen);
    join
    total++; if (!seen || n != STOP_LAT) begin bad++; $display("FAIL a5_latency got=%0d want=%0d", n, STOP_LAT); end
    total++; if (rx_byte !== 8'hA5) begin bad++; $display("FAIL a5_byte got=%h want=a5", rx_byte); end
    rfd = 1'b0;
    tick(1);
    total++; if (dav_ !== 1'b1) begin bad++; $display("FAIL a5_release got=%b want=1", dav_); end
    total++; if (fe !== 1'b0 || ovr !== 1'b0) begin bad++; $display("FAIL a5_flags got=%b%b want=00", fe, ovr); end
  endtask

  task automatic test_glitch();
    int n;
    bit seen;
    int lows;
    do_reset();
    rfd = 1'b1;
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (dav_ === 1'b0) lows++;
    end
    total++; if (lows != 0 || fe !== 1'b0) begin bad++; $display("FAIL glitch_quiet got=lows %0d fe %b want=lows 0 fe 0", lows, fe); end
    total++; if (dut.rx_state !== ricevitore_pkg::R_IDLE) begin bad++; $display("FAIL glitch_idle got=%0d want=%0d", dut.rx_state, ricevitore_pkg::R_IDLE); end
    fork
      send_frame(8'h3C, 1'b1);
      wait_dav(80, n, seen);
    join
    total++; if (!seen || rx_byte !== 8'h3C) begin bad++; $display("FAIL glitch_3c got=%h seen %0d want=3c", rx_byte, seen); end
    rfd = 1'b0;
    tick(1);
  endtask

  task automatic test_framing();
    int n;
    bit seen;
    int lows;
    do_reset();
    rfd = 1'b1;
    lows = 0;
    fork
      begin
        send_frame(8'h81, 1'b0);
        tick(20);
        rxd = 1'b1;
        tick(8);
      end
      for (int i = 0; i < 68; i++) begin
        tick(1);
        if (dav_ === 1'b0) lows++;
      end
    join
    total++; if (fe !== 1'b1) begin bad++; $display("FAIL fe_set got=%b want=1", fe); end
    total++; if (lows != 0) begin bad++; $display("FAIL fe_nodav got=%0d want=0", lows); end
    fork
      send_frame(8'h42, 1'b1);
      wait_dav(80, n, seen);
    join
    total++; if (!seen || rx_byte !== 8'h42) begin bad++; $display("FAIL fe_next got=%h seen %0d want=42", rx_byte, seen); end
    total++; if (fe !== 1'b1) begin bad++; $display("FAIL fe_sticky got=%b want=1", fe); end
    rfd = 1'b0;
    tick(1);
  endtask

  task automatic test_overrun();
    do_reset();
    rfd = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", ovr); end
    total++; if (dav_ !== 1'b1 || rx_byte !== 8'h11) begin bad++; $display("FAIL ovr_hold got=dav %b byte %h want=dav 1 byte 11", dav_, rx_byte); end
    rfd = 1'b1;
    tick(1);
    total++; if (dav_ !== 1'b0 || rx_byte !== 8'h11) begin bad++; $display("FAIL ovr_deliver got=dav %b byte %h want=dav 0 byte 11", dav_, rx_byte); end
    rfd = 1'b0;
    tick(1);
    rfd = 1'b1;
    tick(10);
    total++; if (dav_ !== 1'b1) begin bad++; $display("FAIL ovr_only_one got=%b want=1", dav_); end
    rfd = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rfd = 1'b1;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        tick(50);
        total++; if (dav_ !== 1'b0 || rx_byte !== 8'h11) begin bad++; $display("FAIL b2b_first got=dav %b byte %h want=dav 0 byte 11", dav_, rx_byte); end
        tick(30);
        rfd = 1'b0;
        tick(1);
        total++; if (dav_ !== 1'b1 || rx_byte !== 8'h22 || ovr !== 1'b0) begin bad++; $display("FAIL b2b_load got=dav %b byte %h ovr %b want=dav 1 byte 22 ovr 0", dav_, rx_byte, ovr); end
        rfd = 1'b1;
        tick(1);
        total++; if (dav_ !== 1'b0 || rx_byte !== 8'h22) begin bad++; $display("FAIL b2b_second got=dav %b byte %h want=dav 0 byte 22", dav_, rx_byte); end
      end
    join
    rfd = 1'b0;
    tick(1);
    total++; if (dav_ !== 1'b1 || ovr !== 1'b0) begin bad++; $display("FAIL b2b_done got=dav %b ovr %b want=dav 1 ovr 0", dav_, ovr); end
  endtask

  task automatic test_reset_midframe();
    int n;
    bit seen;
    logic [7:0] d;
    do_reset();
    rfd = 1'b1;
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rxd = d[3];
    tick(HALF);
    reset = 1'b1;
    rxd = 1'b1;
    tick(1);
    total++; if (dav_ !== 1'b1 || fe !== 1'b0 || ovr !== 1'b0 || rx_byte !== 8'h00) begin
      bad++; $display("FAIL mid_reset got=dav %b fe %b ovr %b byte %h want=1 0 0 00", dav_, fe, ovr, rx_byte);
    end
    tick(2);
    reset = 1'b0;
    tick(5);
    fork
      send_frame(8'hFF, 1'b1);
      wait_dav(80, n, seen);
    join
    total++; if (!seen || rx_byte !== 8'hFF) begin bad++; $display("FAIL mid_ff got=%h seen %0d want=ff", rx_byte, seen); end
    rfd = 1'b0;
    tick(1);
    rfd = 1'b1;
    tick(20);
    total++; if (dav_ !== 1'b1) begin bad++; $display("FAIL mid_extra got=%b want=1", dav_); end
    rfd = 1'b0;
  endtask

  task automatic test_random();
    bit done;
    bit exp_fe;
    logic [7:0] d;
    logic [7:0] want;
    bit bad_stop;
    do_reset();
    exp_q.delete();
    rfd = 1'b1;
    done = 0;
    exp_fe = 0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          d = 8'($urandom);
          bad_stop = ($urandom_range(0, 4) == 0);
          if (!bad_stop) exp_q.push_back(d);
          send_frame(d, !bad_stop);
          if (bad_stop) begin
            exp_fe = 1;
            tick($urandom_range(1, 10));
            rxd = 1'b1;
          end
          tick($urandom_range(2, 8));
        end
        tick(60);
        done = 1;
      end
      while (!done) begin
        tick(1);
        if (dav_ === 1'b0 && rfd === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rand_extra got=%h want=none", rx_byte);
          end else begin
            want = exp_q.pop_front();
            if (rx_byte !== want) begin bad++; $display("FAIL rand_byte got=%h want=%h", rx_byte, want); end
          end
          rfd = 1'b0;
        end else if (rfd === 1'b0 && dav_ === 1'b1) begin
          rfd = 1'b1;
        end
      end
    join
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_missing got=%0d want=0", exp_q.size()); end
    total++; if (fe !== exp_fe || ovr !== 1'b0) begin bad++; $display("FAIL rand_flags got=fe %b ovr %b want=fe %b ovr 0", fe, ovr, exp_fe); end
    rfd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
